ctrl_seq: RTL and testbench
===========================

Name: ctrl_seq

Overview:
- Parametrised, multi-cycle successor to the 3BC combinational decoder.
- Decodes the current instruction into register-file and data-memory controls, and adds a run/done sequencer driven by a Start/Ack handshake.
- Stalls the PC for a configurable data-memory latency.
- Counts retired instructions.
- Sits between instruction ROM output, program counter, reg_file and data memory.

Parameters:
- IW, 9: instruction width; opcode is Instruction[IW-1 -: OPW].
- OPW, 4: opcode width.
- WR_MASK, 16'h3F3F: bit i set means opcode i writes reg_file (width 2**OPW).
- LDI_OP, 4'b0000: load-immediate opcode; RegLoadType 2'b00.
- LDR_OP, 4'b0001: load-from-memory opcode; RegLoadType 2'b01; memory op.
- STR_OP, 4'b0110: store opcode; memory op.
- OFFS_OP, 4'b0101: opcode whose branch offset comes from a register (OffsetSrc=1).
- MEM_LAT, 2: extra wait cycles for memory ops (0 allowed).
- CNT_W, 16: retired-instruction counter width.

Ports:
- Clk, input, 1: clock.
- Reset, input, 1: synchronous, active-high reset.
- Start, input, 1: begin program (from IDLE) / acknowledge finish (from DONE).
- Instruction, input, IW: machine code from instruction ROM.
- RegLoadType, output, 2: reg_file data select. 00 = immediate, 01 = memory, 10 = ALU.
- RegWrEn, output, 1: reg_file write enable, one pulse per writing instruction.
- StoreInst, output, 1: data-memory write enable, one pulse per store.
- OffsetSrc, output, 1: 1 = offset from register, 0 = from LUT.
- PcEn, output, 1: advance PC; one pulse per retired instruction.
- Ack, output, 1: program done.
- Illegal, output, 1: illegal-opcode trap flag (see optional feature).
- InstCount, output, CNT_W: retired-instruction count.

Behaviour:
- States: IDLE, EXEC, MEMWAIT, DONE. Registered state, wait counter (width ≥ clog2(MEM_LAT+1)), InstCount, Illegal.
- Outputs are combinational from state + Instruction (Mealy).
- Reset (sync, active-high):
  - Next edge forces IDLE; wait counter 0; InstCount 0; Illegal 0.
  - Outputs RegWrEn/StoreInst/PcEn/Ack/OffsetSrc = 0, RegLoadType = 2'b10.
  - Reset mid-instruction or in MEMWAIT aborts with no write pulse.
  - Reset has priority over Start.
- IDLE:
  - All enables 0.
  - Start=1 → EXEC next cycle, InstCount cleared to 0 on the same edge.
- EXEC, Instruction all-ones (Ack word):
  - → DONE; no RegWrEn/StoreInst/PcEn.
  - Not counted.
- EXEC, memory op (LDR_OP or STR_OP) with MEM_LAT>0:
  - No enables this cycle; load counter = MEM_LAT; → MEMWAIT.
- EXEC, memory op with MEM_LAT=0, or any other op, in the same cycle:
  - PcEn=1.
  - RegWrEn = WR_MASK[opcode].
  - StoreInst = (opcode==STR_OP).
  - Stay in EXEC; InstCount increments on that edge.
- MEMWAIT:
  - Decrement counter each cycle.
  - In the cycle counter==1, assert the commit enables (PcEn, RegWrEn/StoreInst per opcode) → EXEC.
  - Instruction must remain stable (PC frozen).
  - Memory op occupies 1+MEM_LAT cycles.
- RegLoadType decodes opcode in EXEC/MEMWAIT: LDI_OP→00, LDR_OP→01, else 10. 10 in IDLE/DONE.
- OffsetSrc = (opcode==OFFS_OP) in EXEC/MEMWAIT; 0 otherwise.
- DONE:
  - Ack=1, held every cycle; all other enables 0.
  - Start=1 → IDLE next edge (Ack drops); Illegal cleared on that edge.
- Start in EXEC/MEMWAIT is ignored.
- InstCount saturates at all-ones; does not wrap.
- Opcodes with WR_MASK bit 0 other than STR_OP (e.g. 0111, 1110, non-Ack 1111) retire as no-write instructions (PcEn only), unless trapped.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes 4'b1110 and 4'b1111 (except the all-ones Ack word) are illegal.
  - In EXEC: no enables, no PcEn, not counted; → DONE with Illegal set to 1 on that edge.
  - Illegal is sticky until Start in DONE or Reset.
- Undefined: Illegal tied 0; these opcodes retire as no-write no-ops.

Test Plan:
- Reset held 2 cycles, then released → IDLE; all enables 0, RegLoadType=10, InstCount=0, Ack=0.
- Start pulse, then LDI (9'b0000_00101) → 1 cycle later RegWrEn=1, RegLoadType=00, PcEn=1 in the same cycle; InstCount=1.
- LDR with MEM_LAT=2 → cycle0 no enables; cycle1 no enables; cycle2 RegWrEn=1, RegLoadType=01, PcEn=1 (3 cycles total). STR with MEM_LAT=0 → StoreInst=1, PcEn=1 in 1 cycle, RegWrEn=0.
- 9'b111111111 in EXEC → Ack=1 next cycle and held 5 cycles with no PcEn; Start=1 → Ack=0, state IDLE.
- Reset asserted in the 2nd MEMWAIT cycle of an LDR → no RegWrEn pulse ever; IDLE after the edge; InstCount=0.
- With CTRL_ILLEGAL_TRAP_EN, opcode 4'b1110 → Illegal=1, Ack=1, InstCount unchanged. Without the macro → PcEn=1, RegWrEn=0, InstCount+1.

Source files
------------

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: bundles the sequencer's handshake and control signals.
//   master : program/testbench side (drives Start, Instruction; observes the controls)
//   slave  : ctrl_seq side (consumes Start, Instruction; drives the controls)
// Signals: Start, Instruction[IW], RegLoadType[2], RegWrEn, StoreInst,
//          OffsetSrc, PcEn, Ack, Illegal, InstCount[CNT_W].
interface ctrl_seq_if #(
  parameter int IW    = 9,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [IW-1:0]    Instruction;
  logic [1:0]       RegLoadType;
  logic             RegWrEn;
  logic             StoreInst;
  logic             OffsetSrc;
  logic             PcEn;
  logic             Ack;
  logic             Illegal;
  logic [CNT_W-1:0] InstCount;

  modport master (
    output Start, Instruction,
    input  RegLoadType, RegWrEn, StoreInst, OffsetSrc, PcEn, Ack, Illegal, InstCount
  );

  modport slave (
    input  Start, Instruction,
    output RegLoadType, RegWrEn, StoreInst, OffsetSrc, PcEn, Ack, Illegal, InstCount
  );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle instruction decoder / run-done sequencer.
// Decodes the current instruction into reg_file and data-memory controls,
// stalls the PC for MEM_LAT extra cycles on memory ops, counts retired
// instructions (saturating) and runs a Start/Ack handshake.
// Ports:
//   Clk   - clock
//   Reset - synchronous, active-high reset
//   bus   - ctrl_seq_if.slave: Start, Instruction in; RegLoadType, RegWrEn,
//           StoreInst, OffsetSrc, PcEn, Ack, Illegal, InstCount out
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap opcodes
// {1..1,0} and {1..1} (except the all-ones Ack word) into DONE with Illegal set.
module ctrl_seq #(
  parameter int                  IW      = 9,
  parameter int                  OPW     = 4,
  parameter logic [2**OPW-1:0]   WR_MASK = 16'h3F3F,
  parameter logic [OPW-1:0]      LDI_OP  = 4'b0000,
  parameter logic [OPW-1:0]      LDR_OP  = 4'b0001,
  parameter logic [OPW-1:0]      STR_OP  = 4'b0110,
  parameter logic [OPW-1:0]      OFFS_OP = 4'b0101,
  parameter int unsigned         MEM_LAT = 2,
  parameter int                  CNT_W   = 16
) (
  input  logic     Clk,
  input  logic     Reset,
  ctrl_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, MEMWAIT, DONE} state_t;

  // Wait counter needs to hold MEM_LAT; keep at least one bit when MEM_LAT=0.
  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_wait, w_wait_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic [OPW-1:0] w_op;
  logic           w_ack_word, w_is_mem, w_illegal_op;
  logic           w_commit, w_cnt_clr, w_decode, w_ack;

  assign w_op       = bus.Instruction[IW-1 -: OPW];
  assign w_ack_word = &bus.Instruction;
  assign w_is_mem   = (w_op == LDR_OP) || (w_op == STR_OP);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal, w_trap;
  assign w_illegal_op = ((w_op == {OPW{1'b1}}) && !w_ack_word) ||
                        (w_op == {{(OPW-1){1'b1}}, 1'b0});
`else
  assign w_illegal_op = 1'b0;
`endif

  // Next state + Mealy control decode. Reset masks every enable so an
  // instruction caught mid-flight aborts without a write pulse.
  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait;
    w_commit   = 1'b0;
    w_cnt_clr  = 1'b0;
    w_decode   = 1'b0;
    w_ack      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_trap     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_next    = EXEC;
          w_cnt_clr = 1'b1;
        end
      end
      EXEC: begin
        w_decode = 1'b1;
        if (w_ack_word) begin
          w_next = DONE;
        end else if (w_illegal_op) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_trap = 1'b1;
`endif
          w_next = DONE;
        end else if (w_is_mem && (MEM_LAT > 0)) begin
          w_wait_nxt = CW'(MEM_LAT);
          w_next     = MEMWAIT;
        end else begin
          w_commit = 1'b1;
        end
      end
      MEMWAIT: begin
        w_decode   = 1'b1;
        w_wait_nxt = r_wait - CW'(1);
        if (r_wait == CW'(1)) begin
          w_commit = 1'b1;
          w_next   = EXEC;
        end
      end
      DONE: begin
        w_ack = 1'b1;
        if (bus.Start) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (Reset) begin
      w_commit = 1'b0;
      w_decode = 1'b0;
      w_ack    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (w_commit && !(&r_cnt))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Sticky until the DONE->IDLE acknowledge.
  always_ff @(posedge Clk) begin
    if (Reset)
      r_illegal <= 1'b0;
    else if (w_trap)
      r_illegal <= 1'b1;
    else if ((r_state == DONE) && bus.Start)
      r_illegal <= 1'b0;
  end
  assign bus.Illegal = r_illegal;
`else
  assign bus.Illegal = 1'b0;
`endif

  assign bus.RegLoadType = !w_decode          ? 2'b10 :
                           (w_op == LDI_OP)   ? 2'b00 :
                           (w_op == LDR_OP)   ? 2'b01 : 2'b10;
  assign bus.OffsetSrc   = w_decode && (w_op == OFFS_OP);
  assign bus.RegWrEn     = w_commit && WR_MASK[w_op];
  assign bus.StoreInst   = w_commit && (w_op == STR_OP);
  assign bus.PcEn        = w_commit;
  assign bus.Ack         = w_ack;
  assign bus.InstCount   = r_cnt;

endmodule

// File: tb/tb_ctrl_seq.sv
module tb_ctrl_seq;

  logic       Clk;
  logic       Reset;
  logic       tb_start;
  logic [8:0] tb_ins;

  int n_chk = 0;
  int n_err = 0;

  // Main DUT: default parameters (MEM_LAT=2, CNT_W=16)
  ctrl_seq_if #(.IW(9), .CNT_W(16)) bus_a ();
  // Second DUT: MEM_LAT=0 and a 3-bit counter to reach saturation quickly
  ctrl_seq_if #(.IW(9), .CNT_W(3))  bus_b ();

  assign bus_a.Start       = tb_start;
  assign bus_a.Instruction = tb_ins;
  assign bus_b.Start       = tb_start;
  assign bus_b.Instruction = tb_ins;

  ctrl_seq u_dut (.Clk(Clk), .Reset(Reset), .bus(bus_a));
  ctrl_seq #(.MEM_LAT(0), .CNT_W(3)) u_dut0 (.Clk(Clk), .Reset(Reset), .bus(bus_b));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [8:0]  ins;
    logic [1:0]  rlt;
    logic        we, st, os, pc, ack, il;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t vt [NV];

  localparam logic [8:0] I_LDI  = 9'b0000_00101;
  localparam logic [8:0] I_LDR  = 9'b0001_00011;
  localparam logic [8:0] I_OFFS = 9'b0101_00000;
  localparam logic [8:0] I_STR  = 9'b0110_00001;
  localparam logic [8:0] I_OP7  = 9'b0111_00000;
  localparam logic [8:0] I_OP8  = 9'b1000_00010;
  localparam logic [8:0] I_OP14 = 9'b1110_00000;
  localparam logic [8:0] I_ACK  = 9'b1111_11111;

  function automatic vec_t mk(logic rst, logic start, logic [8:0] ins,
                              logic [1:0] rlt, logic we, logic st, logic os,
                              logic pc, logic ack, logic il, logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.start = start; v.ins = ins; v.rlt = rlt;
    v.we = we; v.st = st; v.os = os; v.pc = pc; v.ack = ack; v.il = il; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  initial begin
    //            rst st ins     rlt   we st os pc ak il cnt
    vt[0]  = mk(0, 0, 9'h0,   2'b10, 0, 0, 0, 0, 0, 0, 0); // IDLE after reset
    vt[1]  = mk(0, 1, 9'h0,   2'b10, 0, 0, 0, 0, 0, 0, 0); // start
    vt[2]  = mk(0, 0, I_LDI,  2'b00, 1, 0, 0, 1, 0, 0, 0);
    vt[3]  = mk(0, 0, I_LDR,  2'b01, 0, 0, 0, 0, 0, 0, 1); // LDR cycle0
    vt[4]  = mk(0, 0, I_LDR,  2'b01, 0, 0, 0, 0, 0, 0, 1); // cycle1
    vt[5]  = mk(0, 0, I_LDR,  2'b01, 1, 0, 0, 1, 0, 0, 1); // cycle2 commit
    vt[6]  = mk(0, 0, I_OFFS, 2'b10, 1, 0, 1, 1, 0, 0, 2);
    vt[7]  = mk(0, 0, I_STR,  2'b10, 0, 0, 0, 0, 0, 0, 3);
    vt[8]  = mk(0, 1, I_STR,  2'b10, 0, 0, 0, 0, 0, 0, 3); // Start ignored
    vt[9]  = mk(0, 0, I_STR,  2'b10, 0, 1, 0, 1, 0, 0, 3);
    vt[10] = mk(0, 0, I_OP7,  2'b10, 0, 0, 0, 1, 0, 0, 4); // no-write op
    vt[11] = mk(0, 0, I_OP8,  2'b10, 1, 0, 0, 1, 0, 0, 5);
    vt[12] = mk(0, 0, I_ACK,  2'b10, 0, 0, 0, 0, 0, 0, 6); // Ack word
    for (int i = 13; i < 18; i++)
      vt[i] = mk(0, 0, I_ACK, 2'b10, 0, 0, 0, 0, 1, 0, 6); // DONE held
    vt[18] = mk(0, 1, I_ACK,  2'b10, 0, 0, 0, 0, 1, 0, 6);
    vt[19] = mk(0, 0, 9'h0,   2'b10, 0, 0, 0, 0, 0, 0, 6); // back in IDLE
    vt[20] = mk(0, 1, 9'h0,   2'b10, 0, 0, 0, 0, 0, 0, 6);
    vt[21] = mk(0, 0, I_LDR,  2'b01, 0, 0, 0, 0, 0, 0, 0);
    vt[22] = mk(0, 0, I_LDR,  2'b01, 0, 0, 0, 0, 0, 0, 0);
    vt[23] = mk(1, 0, I_LDR,  2'b10, 0, 0, 0, 0, 0, 0, 0); // reset in 2nd MEMWAIT
    vt[24] = mk(0, 0, 9'h0,   2'b10, 0, 0, 0, 0, 0, 0, 0);
    vt[25] = mk(0, 1, 9'h0,   2'b10, 0, 0, 0, 0, 0, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    vt[26] = mk(0, 0, I_OP14, 2'b10, 0, 0, 0, 0, 0, 0, 0); // trapped
    vt[27] = mk(0, 0, I_ACK,  2'b10, 0, 0, 0, 0, 1, 1, 0);
    vt[28] = mk(0, 1, I_ACK,  2'b10, 0, 0, 0, 0, 1, 1, 0);
    vt[29] = mk(0, 0, 9'h0,   2'b10, 0, 0, 0, 0, 0, 0, 0);
`else
    vt[26] = mk(0, 0, I_OP14, 2'b10, 0, 0, 0, 1, 0, 0, 0); // no-write no-op
    vt[27] = mk(0, 0, I_ACK,  2'b10, 0, 0, 0, 0, 0, 0, 1);
    vt[28] = mk(0, 1, I_ACK,  2'b10, 0, 0, 0, 0, 1, 0, 1);
    vt[29] = mk(0, 0, 9'h0,   2'b10, 0, 0, 0, 0, 0, 0, 1);
`endif

    Reset = 1'b1; tb_start = 1'b0; tb_ins = '0;
    repeat (2) @(posedge Clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      Reset = vt[i].rst; tb_start = vt[i].start; tb_ins = vt[i].ins;
      #1;
      chk("RegLoadType", i, 32'(bus_a.RegLoadType), 32'(vt[i].rlt));
      chk("RegWrEn",     i, 32'(bus_a.RegWrEn),     32'(vt[i].we));
      chk("StoreInst",   i, 32'(bus_a.StoreInst),   32'(vt[i].st));
      chk("OffsetSrc",   i, 32'(bus_a.OffsetSrc),   32'(vt[i].os));
      chk("PcEn",        i, 32'(bus_a.PcEn),        32'(vt[i].pc));
      chk("Ack",         i, 32'(bus_a.Ack),         32'(vt[i].ack));
      chk("Illegal",     i, 32'(bus_a.Illegal),     32'(vt[i].il));
      chk("InstCount",   i, 32'(bus_a.InstCount),   32'(vt[i].cnt));
    end

    // MEM_LAT=0 instance: single-cycle memory ops and counter saturation
    @(negedge Clk); Reset = 1'b1; tb_start = 1'b0; tb_ins = '0;
    @(negedge Clk);
    @(negedge Clk); Reset = 1'b0; tb_start = 1'b1;
    #1;
    chk("b_idle_cnt", 0, 32'(bus_b.InstCount), 32'd0);
    @(negedge Clk); tb_start = 1'b0; tb_ins = I_STR;
    #1;
    chk("b_str_StoreInst", 0, 32'(bus_b.StoreInst), 32'd1);
    chk("b_str_PcEn",      0, 32'(bus_b.PcEn),      32'd1);
    chk("b_str_RegWrEn",   0, 32'(bus_b.RegWrEn),   32'd0);
    @(negedge Clk); tb_ins = I_LDR;
    #1;
    chk("b_ldr_RegWrEn",     0, 32'(bus_b.RegWrEn),     32'd1);
    chk("b_ldr_RegLoadType", 0, 32'(bus_b.RegLoadType), 32'd1);
    chk("b_ldr_PcEn",        0, 32'(bus_b.PcEn),        32'd1);
    chk("b_ldr_cnt",         0, 32'(bus_b.InstCount),   32'd1);
    for (int k = 0; k < 7; k++) begin
      @(negedge Clk); tb_ins = I_LDI;
      #1;
      chk("b_sat_cnt",  k, 32'(bus_b.InstCount), (2 + k > 7) ? 32'd7 : 32'(2 + k));
      chk("b_sat_PcEn", k, 32'(bus_b.PcEn),      32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
